// File: rtl/uart_sample_packetizer.sv
// uart_sample_packetizer: FIFO-buffered sample framer that feeds a UART byte transmitter.
// Define UART_PKT_CHECKSUM_EN to append an XOR checksum byte to every frame.
module uart_sample_packetizer #(
    parameter int         SAMPLE_WIDTH = 16,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [SAMPLE_WIDTH-1:0]     sample_in,
    input  logic                        sample_valid_in,
    output logic                        sample_ready_out,
    input  logic                        busy_in,
    output logic                        trigger_out,
    output logic [7:0]                  data_byte_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_out,
    output logic [15:0]                 drop_count_out
);

    localparam int NBYTES = (SAMPLE_WIDTH + 7) / 8;
    localparam int SW8    = 8 * NBYTES;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
`ifdef UART_PKT_CHECKSUM_EN
    localparam int FRAME_LEN = NBYTES + 2;
`else
    localparam int FRAME_LEN = NBYTES + 1;
`endif
    localparam int IDX_W = $clog2(FRAME_LEN + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_e;

    // FIFO storage and bookkeeping
    logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;
    logic [15:0]             drop_q;
    logic [15:0]             drop_d;
    logic                    push;
    logic                    pop;
    logic                    drop;

    // Framer state
    state_e                  state_q;
    state_e                  state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [SW8-1:0]          shift_q;
    logic [SW8-1:0]          shift_d;
    logic                    trig_q;
    logic                    trig_d;
    logic [7:0]              data_q;
    logic [7:0]              data_d;
    logic [7:0]              frame_byte;
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0]              csum_q;
    logic [7:0]              csum_d;
`endif

    assign sample_ready_out = (count_q != FULL_CNT);
    assign trigger_out      = trig_q;
    assign data_byte_out    = data_q;
    assign fifo_count_out   = count_q;
    assign drop_count_out   = drop_q;

    // FIFO push/pop/drop decisions; a pop frees a slot for a same-cycle push
    always_comb begin
        pop     = (state_q == ST_IDLE) && (count_q != '0) && !busy_in;
        push    = sample_valid_in && ((count_q != FULL_CNT) || pop);
        drop    = sample_valid_in && !push;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        drop_d = drop_q;
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Sample storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    // FIFO pointers, occupancy and saturating drop counter
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Current frame byte: sync, sample bytes MSB-first, then optional checksum
    always_comb begin
        frame_byte = shift_q[SW8-1 -: 8];
        if (idx_q == '0) begin
            frame_byte = SYNC_BYTE;
        end
`ifdef UART_PKT_CHECKSUM_EN
        else if (idx_q == LAST_IDX) begin
            frame_byte = csum_q;
        end
`endif
    end

    // Framer next-state: pop, trigger one byte, wait for busy to rise then fall
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        trig_d  = 1'b0;
        data_d  = data_q;
`ifdef UART_PKT_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    shift_d = SW8'(mem_q[rd_ptr_q]);
                    idx_d   = '0;
`ifdef UART_PKT_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!busy_in) begin
                    data_d  = frame_byte;
                    trig_d  = 1'b1;
`ifdef UART_PKT_CHECKSUM_EN
                    csum_d  = csum_q ^ frame_byte;
`endif
                    if (idx_q != '0) begin
                        shift_d = shift_q << 8;
                    end
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (busy_in) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!busy_in) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Framer registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            trig_q  <= 1'b0;
            data_q  <= 8'h00;
`ifdef UART_PKT_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            trig_q  <= trig_d;
            data_q  <= data_d;
`ifdef UART_PKT_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_sample_packetizer.sv
// tb_uart_sample_packetizer: directed bench with a behavioural UART transmitter model.
// Honours UART_PKT_CHECKSUM_EN for the expected frame length and checksum byte.
module tb_uart_sample_packetizer;

    localparam int DEPTH = 16;
`ifdef UART_PKT_CHECKSUM_EN
    localparam int FL = 4;
`else
    localparam int FL = 3;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid_in = 1'b0;
    logic        sample_ready_out;
    logic        busy_in = 1'b0;
    logic        trigger_out;
    logic [7:0]  data_byte_out;
    logic [4:0]  fifo_count_out;
    logic [15:0] drop_count_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_q[$];
    int         tx_cnt = 0;
    logic       busy_force = 1'b0;
    int         trig_busy = 0;

    uart_sample_packetizer #(
        .SAMPLE_WIDTH(16),
        .FIFO_DEPTH(DEPTH),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .sample_in(sample_in),
        .sample_valid_in(sample_valid_in),
        .sample_ready_out(sample_ready_out),
        .busy_in(busy_in),
        .trigger_out(trigger_out),
        .data_byte_out(data_byte_out),
        .fifo_count_out(fifo_count_out),
        .drop_count_out(drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Transmitter model: latch byte on trigger, busy 1 cycle later for 10 cycles
    always @(posedge clk_in) begin
        if (trigger_out === 1'b1) begin
            cap_q.push_back(data_byte_out);
            if (busy_in) trig_busy++;
            tx_cnt = 10;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
        #1 busy_in = (tx_cnt > 0) || busy_force;
    end

    function automatic logic [7:0] fb(input logic [15:0] s, input int k);
        logic [7:0] c;
        c = 8'hA5 ^ s[15:8] ^ s[7:0];
        case (k)
            0: return 8'hA5;
            1: return s[15:8];
            2: return s[7:0];
            default: return c;
        endcase
    endfunction

    task automatic do_reset();
        rst_n_in = 1'b0;
        sample_valid_in = 1'b0;
        busy_force = 1'b0;
        repeat (15) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic wait_bytes(input int n, input int limit, output bit ok);
        int cyc;
        cyc = 0;
        while (cap_q.size() < n && cyc < limit) begin
            @(negedge clk_in);
            cyc++;
        end
        ok = (cap_q.size() >= n);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (trigger_out !== 1'b0) begin
            errors++; $display("FAIL reset_trigger: got %b want 0", trigger_out);
        end
        checks++;
        if (data_byte_out !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h want 00", data_byte_out);
        end
        checks++;
        if (fifo_count_out !== 5'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", fifo_count_out);
        end
        checks++;
        if (drop_count_out !== 16'd0) begin
            errors++; $display("FAIL reset_drop: got %0d want 0", drop_count_out);
        end
        checks++;
        if (sample_ready_out !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", sample_ready_out);
        end
    endtask

    task automatic test_single();
        int base;
        bit ok;
        logic [15:0] s;
        s = 16'h1234;
        do_reset();
        base = cap_q.size();
        sample_in = s;
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        sample_valid_in = 1'b0;
        checks++;
        if (fifo_count_out !== 5'd1) begin
            errors++; $display("FAIL single_count1: got %0d want 1", fifo_count_out);
        end
        @(negedge clk_in);
        checks++;
        if (trigger_out !== 1'b0 || fifo_count_out !== 5'd0) begin
            errors++;
            $display("FAIL single_pop: trig %b cnt %0d want 0 0", trigger_out, fifo_count_out);
        end
        @(negedge clk_in);
        checks++;
        if (trigger_out !== 1'b1 || data_byte_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_latency: trig %b data %h want 1 a5", trigger_out, data_byte_out);
        end
        @(negedge clk_in);
        checks++;
        if (trigger_out !== 1'b0 || data_byte_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_pulse: trig %b data %h want 0 a5", trigger_out, data_byte_out);
        end
        wait_bytes(base + FL, 300, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_timeout: got %0d bytes want %0d", cap_q.size() - base, FL);
        end
        for (int k = 0; k < FL; k++) begin
            if (base + k < cap_q.size()) begin
                checks++;
                if (cap_q[base + k] !== fb(s, k)) begin
                    errors++;
                    $display("FAIL single_byte%0d: got %h want %h", k, cap_q[base + k], fb(s, k));
                end
            end
        end
        repeat (30) @(negedge clk_in);
        checks++;
        if (cap_q.size() - base !== FL) begin
            errors++; $display("FAIL single_ntrig: got %0d want %0d", cap_q.size() - base, FL);
        end
    endtask

    task automatic test_overflow();
        int base;
        bit ok;
        logic [15:0] s;
        do_reset();
        base = cap_q.size();
        for (int i = 0; i < 20; i++) begin
            sample_in = 16'h3C00 + 16'(i) * 16'h0101;
            sample_valid_in = 1'b1;
            @(negedge clk_in);
        end
        sample_valid_in = 1'b0;
        checks++;
        if (fifo_count_out !== 5'd16) begin
            errors++; $display("FAIL ovf_count: got %0d want 16", fifo_count_out);
        end
        checks++;
        if (drop_count_out !== 16'd3) begin
            errors++; $display("FAIL ovf_drop: got %0d want 3", drop_count_out);
        end
        checks++;
        if (sample_ready_out !== 1'b0) begin
            errors++; $display("FAIL ovf_ready: got %b want 0", sample_ready_out);
        end
        wait_bytes(base + 17 * FL, 8000, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL ovf_timeout: got %0d bytes want %0d", cap_q.size() - base, 17 * FL);
        end
        for (int f = 0; f < 17; f++) begin
            s = 16'h3C00 + 16'(f) * 16'h0101;
            for (int k = 0; k < FL; k++) begin
                if (base + f * FL + k < cap_q.size()) begin
                    checks++;
                    if (cap_q[base + f * FL + k] !== fb(s, k)) begin
                        errors++;
                        $display("FAIL ovf_f%0d_b%0d: got %h want %h", f, k, cap_q[base + f * FL + k], fb(s, k));
                    end
                end
            end
        end
        checks++;
        if (trig_busy !== 0) begin
            errors++; $display("FAIL ovf_trig_busy: got %0d want 0", trig_busy);
        end
        repeat (30) @(negedge clk_in);
    endtask

    task automatic test_busy_hold();
        int base;
        bit ok;
        bit seen;
        do_reset();
        base = cap_q.size();
        busy_force = 1'b1;
        repeat (2) @(negedge clk_in);
        sample_in = 16'hBEEF;
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        sample_valid_in = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (trigger_out !== 1'b0) seen = 1'b1;
            @(negedge clk_in);
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL busy_hold_trig: got trigger want none");
        end
        checks++;
        if (fifo_count_out !== 5'd1) begin
            errors++; $display("FAIL busy_hold_count: got %0d want 1", fifo_count_out);
        end
        busy_force = 1'b0;
        wait_bytes(base + FL, 400, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL busy_release: got %0d bytes want %0d", cap_q.size() - base, FL);
        end
        if (ok) begin
            checks++;
            if (cap_q[base] !== 8'hA5 || cap_q[base + 1] !== 8'hBE || cap_q[base + 2] !== 8'hEF) begin
                errors++;
                $display("FAIL busy_bytes: got %h %h %h want a5 be ef", cap_q[base], cap_q[base + 1], cap_q[base + 2]);
            end
        end
        checks++;
        if (trig_busy !== 0) begin
            errors++; $display("FAIL busy_trig_busy: got %0d want 0", trig_busy);
        end
        repeat (30) @(negedge clk_in);
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        do_reset();
        base = cap_q.size();
        sample_in = 16'h1234;
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        sample_in = 16'h5678;
        @(negedge clk_in);
        sample_valid_in = 1'b0;
        wait_bytes(base + 2, 200, ok);
        checks++;
        if (!ok || data_byte_out !== 8'h12 || fifo_count_out !== 5'd1) begin
            errors++;
            $display("FAIL mid_pre: data %h cnt %0d want 12 1", data_byte_out, fifo_count_out);
        end
        #2 rst_n_in = 1'b0;
        #1;
        checks++;
        if (trigger_out !== 1'b0 || data_byte_out !== 8'h00 || fifo_count_out !== 5'd0 ||
            drop_count_out !== 16'd0 || sample_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: trig %b data %h cnt %0d drop %0d rdy %b", trigger_out,
                     data_byte_out, fifo_count_out, drop_count_out, sample_ready_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (60) @(negedge clk_in);
        checks++;
        if (cap_q.size() !== base + 2) begin
            errors++; $display("FAIL mid_no_trig: got %0d bytes want 2", cap_q.size() - base);
        end
    endtask

    task automatic test_push_pop_full();
        int base;
        bit ok;
        logic [15:0] s;
        do_reset();
        base = cap_q.size();
        busy_force = 1'b1;
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < 17; i++) begin
            sample_in = 16'h4000 + 16'(i) * 16'h0101;
            sample_valid_in = 1'b1;
            @(negedge clk_in);
        end
        sample_valid_in = 1'b0;
        checks++;
        if (fifo_count_out !== 5'd16 || drop_count_out !== 16'd1) begin
            errors++;
            $display("FAIL ppf_fill: cnt %0d drop %0d want 16 1", fifo_count_out, drop_count_out);
        end
        busy_force = 1'b0;
        @(negedge clk_in);
        sample_in = 16'h7E81;
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        sample_valid_in = 1'b0;
        checks++;
        if (fifo_count_out !== 5'd16) begin
            errors++; $display("FAIL ppf_count: got %0d want 16", fifo_count_out);
        end
        checks++;
        if (drop_count_out !== 16'd1) begin
            errors++; $display("FAIL ppf_drop: got %0d want 1", drop_count_out);
        end
        wait_bytes(base + 17 * FL, 8000, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL ppf_timeout: got %0d bytes want %0d", cap_q.size() - base, 17 * FL);
        end
        if (ok) begin
            s = 16'h4000;
            for (int k = 0; k < FL; k++) begin
                checks++;
                if (cap_q[base + k] !== fb(s, k)) begin
                    errors++;
                    $display("FAIL ppf_first_b%0d: got %h want %h", k, cap_q[base + k], fb(s, k));
                end
            end
            s = 16'h7E81;
            for (int k = 0; k < FL; k++) begin
                checks++;
                if (cap_q[base + 16 * FL + k] !== fb(s, k)) begin
                    errors++;
                    $display("FAIL ppf_last_b%0d: got %h want %h", k, cap_q[base + 16 * FL + k], fb(s, k));
                end
            end
        end
        repeat (30) @(negedge clk_in);
    endtask

    task automatic test_saturate();
        do_reset();
        busy_force = 1'b1;
        repeat (2) @(negedge clk_in);
        sample_in = 16'h0000;
        sample_valid_in = 1'b1;
        repeat (16 + 65534) @(negedge clk_in);
        checks++;
        if (drop_count_out !== 16'hFFFE) begin
            errors++; $display("FAIL sat_fffe: got %h want fffe", drop_count_out);
        end
        @(negedge clk_in);
        checks++;
        if (drop_count_out !== 16'hFFFF) begin
            errors++; $display("FAIL sat_ffff: got %h want ffff", drop_count_out);
        end
        repeat (5) @(negedge clk_in);
        sample_valid_in = 1'b0;
        checks++;
        if (drop_count_out !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got %h want ffff", drop_count_out);
        end
        checks++;
        if (fifo_count_out !== 5'd16 || sample_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL sat_full: cnt %0d rdy %b want 16 0", fifo_count_out, sample_ready_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_busy_hold();
        test_reset_mid();
        test_push_pop_full();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
